ps2_rx_fifo: RTL and testbench
==============================

Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver. It synchronises and glitch-filters ps2_clk, then deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop). Every field is checked, and a stalled frame is aborted on timeout. Good scan codes are buffered in a show-ahead FIFO, so the keyboard-mapping logic can consume them at its own pace instead of catching single-cycle strobes.

Parameters:
SYNC_STAGES, 2, flip-flop synchroniser depth for ps2_clk and ps2_data (min 2)
FILTER_LEN, 4, consecutive equal synchronised ps2_clk samples required before the filtered clock changes (min 1)
TIMEOUT_CYCLES, 50000, clk cycles allowed between filtered falling edges inside a frame (2 ms at 25 MHz)
FIFO_DEPTH, 8, scan-code entries; power of two, min 2

Ports:
clk  input  1  system clock (25 MHz nominal)
reset  input  1  synchronous, active-high reset
ps2_clk  input  1  asynchronous PS/2 clock from Pmod
ps2_data  input  1  asynchronous PS/2 data from Pmod
rd_en  input  1  pop head entry; honoured only when valid=1
scan_code  output  8  FIFO head; meaningful only while valid=1
valid  output  1  FIFO non-empty
count  output  $clog2(FIFO_DEPTH)+1  entries held
parity_err  output  1  one-cycle pulse: frame dropped on parity mismatch
frame_err  output  1  one-cycle pulse: bad start bit, bad stop bit or timeout
overflow  output  1  one-cycle pulse: good frame dropped because FIFO was full

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Reset state:
  - valid=0, count=0, scan_code=0x00, all error pulses 0.
  - FSM in IDLE, filtered clock=1, synchronisers=1, timeout counter=0.
  - FIFO contents discarded.
- Reset asserted mid-frame: the partial frame is lost with no error pulse.
- Filter: the filtered clock takes the synchronised value once FILTER_LEN consecutive samples agree.
- Falling edge: filtered clock goes 1->0. ps2_data is sampled from its synchroniser output on that cycle.
- FSM states and transitions:
  - IDLE: falling edge with data=0 -> DATA, bit index=0. Falling edge with data=1 -> frame_err pulse, stay IDLE.
  - DATA: each edge shifts data into bit[index], LSB first. After the 8th bit -> PARITY.
  - PARITY: captures the parity bit -> STOP.
  - STOP: the edge samples the stop bit, then -> IDLE in all cases. Outcome is checked in this order:
    - stop=0 -> frame_err, frame dropped.
    - else XOR of 8 data bits and parity bit = 0 -> parity_err, frame dropped.
    - else a push request for the byte.
- Timeout counter:
  - Clears on every falling edge and in IDLE; otherwise increments.
  - Reaching TIMEOUT_CYCLES-1 in DATA/PARITY/STOP -> frame_err pulse, FSM -> IDLE, partial byte discarded.
  - An edge on the same cycle as the timeout wins: the edge is processed and no timeout fires.
- Push timing: the push occurs on the cycle after the stop edge. valid/scan_code update on the following cycle.
- FIFO:
  - Show-ahead: scan_code always reflects the head entry.
  - Pop: rd_en with valid=1 advances the head next cycle. rd_en while empty is ignored.
- Full and simultaneous events:
  - Push while full without a pop -> new byte dropped, overflow pulse; contents unchanged.
  - Push and pop in the same cycle -> both happen, count unchanged. This includes the full case, where no overflow occurs.
  - Pointers wrap modulo FIFO_DEPTH.
- At most one error pulse is asserted per cycle.

Decomposition:
- Package ps2_pkg:
  - rx_state_t enum: IDLE, DATA, PARITY, STOP.
  - PS2_DATA_BITS=8.
  - Scan-code constants used by consumers: BREAK=0xF0, EXTEND=0xE0.
- One sub-module, sync_fifo: parameters WIDTH and DEPTH, show-ahead, with push/pop/full/empty/count. It will be reused by the keyboard-mapping stage.
- The synchroniser and filter stay inline.

Test Plan:
- Frames with 40 µs ps2_clk period:
  - Send 0x1C (parity 0) -> one entry, scan_code=0x1C, valid=1, count=1, no error pulses.
  - Pop with rd_en -> valid=0 next cycle.
- Back-to-back 0xF0 (parity 1) then 0x1C, no reads -> count=2. Head 0xF0, then 0x1C after one pop.
- Error frames:
  - 0x1C sent with parity 1 -> parity_err once, count stays 0.
  - 0x1C sent with stop=0 -> frame_err once, count stays 0.
  - Receiver accepts a following good 0x32.
- Send start + 4 data bits, then hold ps2_clk high -> frame_err exactly TIMEOUT_CYCLES-1 cycles after the last edge. A following good 0x1C is received correctly.
- Fill with FIFO_DEPTH codes 0x01..0x08, send 0x09 -> overflow pulse, count=8, head 0x01. Then send 0x0A, asserting rd_en on the push cycle -> no overflow, count=8, tail is 0x0A.
- Filter and reset:
  - 2-cycle low glitch on ps2_clk in IDLE -> no state change, no frame_err.
  - reset asserted after the 5th bit of a frame -> all outputs at reset values, next full frame 0x1C received correctly.

Source files
------------

// File: rtl/ps2_rx_fifo_pkg.sv
// Shared PS/2 receive types and scan-code constants.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int PS2_DATA_BITS = 8;

  // Prefix codes the keyboard-mapping stage looks for.
  localparam logic [7:0] BREAK  = 8'hF0;
  localparam logic [7:0] EXTEND = 8'hE0;

  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                     input logic                     par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// Single-clock show-ahead FIFO: rd_data always presents the head entry.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign count   = cnt_q;
  // Head is forced to zero while empty so nothing stale leaks out after reset.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer/count next state; a pop frees the slot a same-cycle push needs when full.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control registers; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array, written only on an accepted push; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchroniser, clock glitch filter, frame
// deframer with parity/framing/timeout checks, and a show-ahead scan-code FIFO.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  output logic [7:0]                    scan_code,
  output logic                          valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int IDX_W  = $clog2(PS2_DATA_BITS);

  localparam logic [FCNT_W-1:0] FILT_LAST = FCNT_W'(FILTER_LEN - 1);
  // Fire one cycle early so the registered pulse lands when the count reaches TIMEOUT_CYCLES-1.
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 2);
  localparam logic [IDX_W-1:0]  BIT_LAST  = IDX_W'(PS2_DATA_BITS - 1);

  logic [SYNC_STAGES-1:0]   clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0]   data_sync_q, data_sync_d;
  logic                     clk_s, data_s;
  logic                     filt_q, filt_d;
  logic [FCNT_W-1:0]        fcnt_q, fcnt_d;
  logic                     fall;

  rx_state_t                state_q, state_d;
  logic [IDX_W-1:0]         bit_idx_q, bit_idx_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
  logic                     par_q, par_d;
  logic                     push_q, push_d;
  logic                     perr_q, perr_d;
  logic                     ferr_q, ferr_d;
  logic                     ovf_q, ovf_d;

  logic                     fifo_full, fifo_empty;

  assign clk_s      = clk_sync_q[SYNC_STAGES-1];
  assign data_s     = data_sync_q[SYNC_STAGES-1];
  assign valid      = ~fifo_empty;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;

  // Synchroniser shift and glitch filter: flip only after FILTER_LEN disagreeing samples.
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    filt_d      = filt_q;
    fcnt_d      = '0;
    if (clk_s != filt_q) begin
      if (fcnt_q == FILT_LAST) filt_d = clk_s;
      else                     fcnt_d = fcnt_q + 1'b1;
    end
    fall = filt_q & ~filt_d;
  end

  // Deframer FSM next state, timeout tracking and error/overflow pulse generation.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    push_d    = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    tmo_d     = (fall || state_q == IDLE) ? '0 : tmo_q + 1'b1;
    ovf_d     = push_q & fifo_full & ~(rd_en & ~fifo_empty);
    if (fall) begin
      case (state_q)
        IDLE: begin
          if (!data_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            ferr_d = 1'b1;
          end
        end
        DATA: begin
          shift_d[bit_idx_q] = data_s;
          if (bit_idx_q == BIT_LAST) state_d = PARITY;
          else                       bit_idx_d = bit_idx_q + 1'b1;
        end
        PARITY: begin
          par_d   = data_s;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!data_s)                        ferr_d = 1'b1;
          else if (!parity_ok(shift_q, par_q)) perr_d = 1'b1;
          else                                push_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TMO_LAST) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
    end
  end

  // Control state; synchronisers and filtered clock idle high like the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      filt_q      <= 1'b1;
      fcnt_q      <= '0;
      state_q     <= IDLE;
      bit_idx_q   <= '0;
      tmo_q       <= '0;
      push_q      <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      filt_q      <= filt_d;
      fcnt_q      <= fcnt_d;
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      tmo_q       <= tmo_d;
      push_q      <= push_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovf_q       <= ovf_d;
    end
  end

  // Received byte and parity bit; only consumed after a complete frame.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  sync_fifo #(
    .WIDTH (PS2_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_q),
    .pop     (rd_en),
    .wr_data (shift_q),
    .rd_data (scan_code),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo with a shortened PS/2 bit period and timeout.
module tb_ps2_rx_fifo;

  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int TMO  = 200;
  localparam int DEP  = 8;
  localparam int HALF = 40;  // ps2_clk half period in clk cycles
  // Cycles from driving ps2_clk low to the frame_err timeout pulse.
  localparam int TMO_LAT = (SYNC - 1) + FILT + (TMO - 1);

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic       rd_en;
  logic [7:0] scan_code;
  logic       valid;
  logic [3:0] count;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int n_ferr = 0;
  int n_perr = 0;
  int n_ovf = 0;
  int n_multi = 0;

  always #5 clk = ~clk;

  ps2_rx_fifo #(
    .SYNC_STAGES    (SYNC),
    .FILTER_LEN     (FILT),
    .TIMEOUT_CYCLES (TMO),
    .FIFO_DEPTH     (DEP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rd_en      (rd_en),
    .scan_code  (scan_code),
    .valid      (valid),
    .count      (count),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_err === 1'b1)  n_ferr <= n_ferr + 1;
    if (parity_err === 1'b1) n_perr <= n_perr + 1;
    if (overflow === 1'b1)   n_ovf  <= n_ovf + 1;
    if ((32'(frame_err) + 32'(parity_err) + 32'(overflow)) > 1) n_multi <= n_multi + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic par, input logic stop);
    return {stop, par, b, 1'b0};
  endfunction

  function automatic logic [10:0] good(input logic [7:0] b);
    return frame(b, ~^b, 1'b1);
  endfunction

  // Drives nbits of a frame LSB first; optionally pops on the FIFO push cycle.
  task automatic send(input logic [10:0] bits, input int nbits, input bit pop_at_push);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (pop_at_push && i == 10) begin
        repeat (6) @(posedge clk);
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        repeat (HALF - 7) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic pop1();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    int ferr0, perr0, first_k;
    logic [7:0] exp_head [8];
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_count", count, 0);
    chk("rst_scan", scan_code, 8'h00);
    chk("rst_errs", {parity_err, frame_err, overflow}, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Single good frame, then pop.
    send(good(8'h1C), 11, 1'b0);
    chk("f1_valid", valid, 1);
    chk("f1_count", count, 1);
    chk("f1_scan", scan_code, 8'h1C);
    chk("f1_noerr", n_ferr + n_perr + n_ovf, 0);
    pop1();
    chk("pop_valid", valid, 0);

    // Back-to-back frames without reads.
    send(good(8'hF0), 11, 1'b0);
    send(good(8'h1C), 11, 1'b0);
    chk("b2b_count", count, 2);
    chk("b2b_head0", scan_code, 8'hF0);
    pop1();
    chk("b2b_head1", scan_code, 8'h1C);
    chk("b2b_count1", count, 1);
    pop1();

    // Parity and stop-bit errors, then a good frame.
    send(frame(8'h1C, 1'b1, 1'b1), 11, 1'b0);
    chk("perr_cnt", n_perr, 1);
    chk("perr_count", count, 0);
    send(frame(8'h1C, 1'b0, 1'b0), 11, 1'b0);
    chk("stop_ferr", n_ferr, 1);
    chk("stop_count", count, 0);
    send(good(8'h32), 11, 1'b0);
    chk("after_err_scan", scan_code, 8'h32);
    chk("after_err_count", count, 1);
    chk("after_err_perr", n_perr, 1);
    pop1();

    // Stalled frame: start + d0..d2 normally, then d3 edge timed precisely.
    send(good(8'h1C), 4, 1'b0);
    ferr0 = n_ferr;
    @(negedge clk);
    ps2_data = 1'b1;  // bit 3 of 0x1C
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    first_k = -1;
    for (int k = 0; k < 2 * TMO; k++) begin
      @(posedge clk);
      #1;
      if (k == HALF) ps2_clk = 1'b1;
      if (frame_err === 1'b1 && first_k < 0) first_k = k;
    end
    chk("tmo_latency", first_k, TMO_LAT);
    @(negedge clk);
    chk("tmo_once", n_ferr - ferr0, 1);
    chk("tmo_count", count, 0);
    send(good(8'h1C), 11, 1'b0);
    chk("tmo_next_scan", scan_code, 8'h1C);
    chk("tmo_next_count", count, 1);
    pop1();

    // Two-cycle glitch while idle must be filtered out.
    ferr0 = n_ferr;
    @(negedge clk);
    ps2_data = 1'b1;
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (3 * HALF) @(negedge clk);
    chk("glitch_ferr", n_ferr - ferr0, 0);
    chk("glitch_count", count, 0);

    // Pop while empty is ignored.
    pop1();
    chk("empty_pop_count", count, 0);
    chk("empty_pop_valid", valid, 0);

    // Fill, overflow, then push with simultaneous pop while full.
    for (int i = 1; i <= DEP; i++) send(good(8'(i)), 11, 1'b0);
    chk("full_count", count, DEP);
    chk("full_head", scan_code, 8'h01);
    send(good(8'h09), 11, 1'b0);
    chk("ovf_pulse", n_ovf, 1);
    chk("ovf_count", count, DEP);
    chk("ovf_head", scan_code, 8'h01);
    send(good(8'h0A), 11, 1'b1);
    chk("pp_no_ovf", n_ovf, 1);
    chk("pp_count", count, DEP);
    exp_head = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
    for (int i = 0; i < DEP; i++) begin
      chk($sformatf("drain_%0d", i), scan_code, exp_head[i]);
      pop1();
    end
    chk("drain_count", count, 0);

    // Reset mid-frame with an entry buffered.
    send(good(8'h32), 11, 1'b0);
    chk("pre_rst_count", count, 1);
    ferr0 = n_ferr;
    perr0 = n_perr;
    send(good(8'h1C), 5, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_scan", scan_code, 8'h00);
    reset = 1'b0;
    repeat (TMO + 50) @(negedge clk);
    chk("mid_rst_noerr", (n_ferr - ferr0) + (n_perr - perr0), 0);
    send(good(8'h1C), 11, 1'b0);
    chk("post_rst_scan", scan_code, 8'h1C);
    chk("post_rst_count", count, 1);
    chk("post_rst_noerr", n_ferr - ferr0, 0);

    chk("one_err_per_cycle", n_multi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
